decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode.sv | 127 ++++++++++++
 tb/tb_decode.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// decode: RV32I decode stage with registered outputs and load-use bubble; CSR ops enabled by DECODE_CSR_EN
module decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [3:0]  in_exception,
    input  logic        in_exception_valid,
    output logic        stall_up,
    input  logic        stall_down,
    input  logic        flush,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_imm,
    output logic [31:0] out_op1,
    output logic [31:0] out_op2,
    output logic [4:0]  out_rd,
    output logic [2:0]  out_funct3,
    output logic [2:0]  out_class,
    output logic [3:0]  out_alu_op,
    output logic [3:0]  out_exception,
    output logic        out_exception_valid
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] BUBBLE = 1'b1;
    logic [0:0]  state;
    logic [4:0]  last_rd;
    logic [6:0]  opc;
    logic [2:0]  f3, cls;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0]  alu_op;
    logic        is_op, is_opimm, is_fence, is_load, is_store, is_br;
    logic        is_jal, is_jalr, is_lui, is_auipc, is_sys, sys_ok;
    logic        legal, exc_any, use1, use2, hazard, accept;
    assign opc      = in_instr[6:0];
    assign f3       = in_instr[14:12];
    assign rd       = in_instr[11:7];
    assign rs1      = in_instr[19:15];
    assign rs2      = in_instr[24:20];
    assign is_op    = opc == 7'b0110011;
    assign is_opimm = opc == 7'b0010011;
    assign is_fence = opc == 7'b0001111;
    assign is_load  = opc == 7'b0000011;
    assign is_store = opc == 7'b0100011;
    assign is_br    = opc == 7'b1100011;
    assign is_jal   = opc == 7'b1101111;
    assign is_jalr  = opc == 7'b1100111;
    assign is_lui   = opc == 7'b0110111;
    assign is_auipc = opc == 7'b0010111;
    assign is_sys   = opc == 7'b1110011;
`ifdef DECODE_CSR_EN
    assign sys_ok = 1'b1;
`else
    assign sys_ok = f3 == 3'd0;
`endif
    assign legal   = is_op | is_opimm | is_fence | is_load | is_store | is_br | is_jal |
                     is_jalr | is_lui | is_auipc | (is_sys & sys_ok);
    assign exc_any = in_exception_valid | ~legal;
    assign cls     = is_load ? 3'd1 : is_store ? 3'd2 : is_br ? 3'd3 : is_jal ? 3'd4 :
                     is_jalr ? 3'd5 : (is_lui | is_auipc) ? 3'd6 : is_sys ? 3'd7 : 3'd0;
    assign imm_i   = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u   = {in_instr[31:12], 12'd0};
    assign imm_j   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign imm     = (is_opimm | is_fence | is_load | is_jalr) ? imm_i : is_store ? imm_s :
                     is_br ? imm_b : (is_lui | is_auipc) ? imm_u : is_jal ? imm_j :
                     is_sys ? {20'd0, in_instr[31:20]} : 32'd0;
    assign alu_op  = {in_instr[30] & ~(is_opimm & f3 != 3'd1 & f3 != 3'd5), f3};
    // CSR immediate forms (funct3[2]=1) carry a uimm, not a register, in the rs1 field
    assign use1    = legal & (is_op | is_opimm | is_load | is_store | is_br | is_jalr |
                     (is_sys & f3 != 3'd0 & ~f3[2]));
    assign use2    = is_op | is_store | is_br;
    assign hazard  = state == IDLE & last_rd != 5'd0 &
                     ((use1 & rs1 == last_rd) | (use2 & rs2 == last_rd));
    assign stall_up    = ~flush & (stall_down | (hazard & in_valid));
    assign accept      = in_valid & ~stall_up & ~flush;
    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;
    // Output bundle, hazard FSM and last-issued-load tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid           <= 1'b0;
            out_exception_valid <= 1'b0;
            out_exception       <= 4'd0;
            out_pc              <= RESET_PC;
            out_imm             <= 32'd0;
            out_op1             <= 32'd0;
            out_op2             <= 32'd0;
            out_rd              <= 5'd0;
            out_funct3          <= 3'd0;
            out_class           <= 3'd0;
            out_alu_op          <= 4'd0;
            state               <= IDLE;
            last_rd             <= 5'd0;
        end else if (flush) begin
            out_valid           <= 1'b0;
            out_exception_valid <= 1'b0;
            state               <= IDLE;
            last_rd             <= 5'd0;
        end else if (!stall_down) begin
            out_valid           <= accept;
            out_exception_valid <= accept & exc_any;
            state               <= (hazard & in_valid) ? BUBBLE : IDLE;
            last_rd             <= (accept & is_load & ~exc_any) ? rd : 5'd0;
            if (accept) begin
                out_pc        <= in_pc;
                out_imm       <= imm;
                out_op1       <= rf_rs1_data;
                out_op2       <= rf_rs2_data;
                out_rd        <= (is_store | is_br) ? 5'd0 : rd;
                out_funct3    <= f3;
                out_class     <= cls;
                out_alu_op    <= alu_op;
                out_exception <= in_exception_valid ? in_exception : (legal ? 4'd0 : 4'd2);
            end
        end
    end
endmodule

// File: tb/tb_decode.sv
// tb_decode: directed and randomized checks of decode against a behavioural RV32I decode model
module tb_decode;
    localparam logic [31:0] RPC = 32'h0000_1000;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_exception_valid, stall_down, flush;
    logic [31:0] in_instr, in_pc;
    logic [3:0]  in_exception;
    logic        stall_up, out_valid, out_exception_valid;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr, out_rd;
    logic [31:0] rf_rs1_data, rf_rs2_data, out_pc, out_imm, out_op1, out_op2;
    logic [2:0]  out_funct3, out_class;
    logic [3:0]  out_alu_op, out_exception;
    logic [31:0] rf [32];
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic        valid, excv;
        logic [31:0] pc, imm, op1, op2;
        logic [4:0]  rd;
        logic [2:0]  f3, cls;
        logic [3:0]  alu, exc;
    } bun_t;

    typedef struct packed {
        logic        ill;
        logic [2:0]  cls;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [4:0]  rd;
    } dec_t;

    bun_t m;

    decode #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_exception(in_exception), .in_exception_valid(in_exception_valid),
        .stall_up(stall_up), .stall_down(stall_down), .flush(flush),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_imm(out_imm), .out_op1(out_op1),
        .out_op2(out_op2), .out_rd(out_rd), .out_funct3(out_funct3), .out_class(out_class),
        .out_alu_op(out_alu_op), .out_exception(out_exception),
        .out_exception_valid(out_exception_valid)
    );

    always #5 clk = ~clk;
    assign rf_rs1_data = rf[rf_rs1_addr];
    assign rf_rs2_data = rf[rf_rs2_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference decode: immediates built arithmetically from the RV32I field layout
    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        logic signed [31:0] s;
        logic [6:0] o;
        logic [2:0] f;
        s = i;
        o = i[6:0];
        f = i[14:12];
        d.ill = 1'b0;
        d.cls = 3'd0;
        d.imm = 32'd0;
        d.rd  = i[11:7];
        d.alu = {i[30] & !(o == 7'h13 && f != 3'd1 && f != 3'd5), f};
        case (o)
            7'h33: ;
            7'h13, 7'h0f: d.imm = 32'(s >>> 20);
            7'h03: begin d.cls = 3'd1; d.imm = 32'(s >>> 20); end
            7'h23: begin d.cls = 3'd2; d.rd = 5'd0; d.imm = (32'(s >>> 25) << 5) | 32'(i[11:7]); end
            7'h63: begin
                d.cls = 3'd3; d.rd = 5'd0;
                d.imm = (32'(s >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            end
            7'h6f: begin
                d.cls = 3'd4;
                d.imm = (32'(s >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            end
            7'h67: begin d.cls = 3'd5; d.imm = 32'(s >>> 20); end
            7'h37, 7'h17: begin d.cls = 3'd6; d.imm = i & 32'hFFFF_F000; end
            7'h73: begin
                d.cls = 3'd7;
                d.imm = 32'(i[31:20]);
`ifndef DECODE_CSR_EN
                if (f != 3'd0) d.ill = 1'b1;
`endif
            end
            default: d.ill = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic uses_rs1(input logic [31:0] i);
        logic [6:0] o;
        o = i[6:0];
        return !ref_decode(i).ill && ((o inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67}) ||
               (o == 7'h73 && i[14:12] != 3'd0 && !i[14]));
    endfunction

    function automatic logic uses_rs2(input logic [31:0] i);
        return i[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    // One clock: predict stall_up and the next bundle, clock, then compare
    task automatic step();
        bun_t n;
        dec_t d;
        logic hz;
        #1;
        d  = ref_decode(in_instr);
        hz = in_valid && m.valid && !m.excv && m.cls == 3'd1 && m.rd != 5'd0 &&
             ((uses_rs1(in_instr) && in_instr[19:15] == m.rd) || (uses_rs2(in_instr) && in_instr[24:20] == m.rd));
        check("stall_up", stall_up, !flush && (stall_down || hz));
        check("rs1_addr", rf_rs1_addr, in_instr[19:15]);
        check("rs2_addr", rf_rs2_addr, in_instr[24:20]);
        n = m;
        if (reset) begin
            n = '{default: '0};
            n.pc = RPC;
        end else if (flush) begin
            n.valid = 1'b0; n.excv = 1'b0;
        end else if (!stall_down) begin
            if (in_valid && !hz) begin
                n.valid = 1'b1; n.pc = in_pc; n.imm = d.imm; n.rd = d.rd; n.cls = d.cls; n.alu = d.alu;
                n.op1 = rf[in_instr[19:15]]; n.op2 = rf[in_instr[24:20]]; n.f3 = in_instr[14:12];
                n.excv = in_exception_valid || d.ill;
                n.exc  = in_exception_valid ? in_exception : (d.ill ? 4'd2 : 4'd0);
            end else begin
                n.valid = 1'b0; n.excv = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m = n;
        check("out_valid", out_valid, m.valid);
        check("out_exc_valid", out_exception_valid, m.excv);
        if (m.valid) begin
            check("out_pc", out_pc, m.pc);
            check("out_exc", out_exception, m.exc);
            if (!m.excv) begin
                check("out_imm", out_imm, m.imm);
                check("out_op1", out_op1, m.op1);
                check("out_op2", out_op2, m.op2);
                check("out_rd", out_rd, m.rd);
                check("out_funct3", out_funct3, m.f3);
                check("out_class", out_class, m.cls);
                check("out_alu_op", out_alu_op, m.alu);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v; in_instr = ins; in_pc = pc;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [15];
        logic [31:0] i;
        ops = '{7'h33, 7'h13, 7'h0f, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73,
                7'h03, 7'h7f, 7'h2b, 7'h00};
        i = $urandom;
        if ($urandom_range(0, 19) != 0) begin
            i[6:0]   = ops[$urandom_range(0, 14)];
            i[11:7]  = 5'($urandom_range(0, 3));
            i[19:15] = 5'($urandom_range(0, 3));
            i[24:20] = 5'($urandom_range(0, 3));
        end
        return i;
    endfunction

    initial begin
        m = '{default: '0};
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        reset = 1'b1; flush = 1'b0; stall_down = 1'b0;
        in_exception_valid = 1'b0; in_exception = 4'd0;
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        step();
        check("rst_pc", out_pc, RPC);
        check("rst_imm", out_imm, 32'd0);
        check("rst_op1", out_op1, 32'd0);
        check("rst_op2", out_op2, 32'd0);
        check("rst_rd", out_rd, 32'd0);
        check("rst_class", out_class, 32'd0);
        check("rst_alu", out_alu_op, 32'd0);
        check("rst_f3", out_funct3, 32'd0);
        check("rst_exc", out_exception, 32'd0);
        reset = 1'b0;
        drive(1'b1, 32'h0050_0093, 32'h0);
        step();
        check("addi_valid", out_valid, 1'b1);
        check("addi_class", out_class, 3'd0);
        check("addi_rd", out_rd, 5'd1);
        check("addi_imm", out_imm, 32'd5);
        check("addi_alu", out_alu_op, 4'd0);
        drive(1'b1, 32'h0000_A103, 32'h4);
        step();
        drive(1'b1, 32'h0011_01B3, 32'h8);
        #1 check("lu_stall", stall_up, 1'b1);
        step();
        check("lu_bubble", out_valid, 1'b0);
        step();
        check("lu_add_valid", out_valid, 1'b1);
        check("lu_add_rd", out_rd, 5'd3);
        check("lu_add_pc", out_pc, 32'h8);
        drive(1'b1, 32'h0000_0000, 32'hC);
        step();
        check("ill_valid", out_valid, 1'b1);
        check("ill_excv", out_exception_valid, 1'b1);
        check("ill_exc", out_exception, 4'd2);
        drive(1'b1, 32'h3000_9073, 32'h10);
        step();
`ifdef DECODE_CSR_EN
        check("csr_class", out_class, 3'd7);
        check("csr_imm", out_imm, 32'h300);
        check("csr_excv", out_exception_valid, 1'b0);
`else
        check("csr_excv", out_exception_valid, 1'b1);
        check("csr_exc", out_exception, 4'd2);
`endif
        drive(1'b1, 32'h0000_0073, 32'h14);
        step();
        check("ecall_class", out_class, 3'd7);
        check("ecall_excv", out_exception_valid, 1'b0);
        drive(1'b1, 32'h0010_0093, 32'h40);
        step();
        stall_down = 1'b1;
        drive(1'b1, 32'h0020_0113, 32'h44);
        for (int k = 0; k < 3; k++) begin
            step();
            check("sd_pc", out_pc, 32'h40);
            check("sd_imm", out_imm, 32'd1);
            check("sd_valid", out_valid, 1'b1);
        end
        flush = 1'b1;
        step();
        check("sd_flush_valid", out_valid, 1'b0);
        flush = 1'b0; stall_down = 1'b0;
        in_exception_valid = 1'b1; in_exception = 4'd0;
        drive(1'b1, 32'h0000_0000, 32'h48);
        step();
        check("pass_excv", out_exception_valid, 1'b1);
        check("pass_exc", out_exception, 4'd0);
        check("pass_valid", out_valid, 1'b1);
        in_exception_valid = 1'b0;
        drive(1'b1, 32'h0000_A103, 32'h50);
        step();
        drive(1'b1, 32'h0011_01B3, 32'h54);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("post_rst_add", out_valid, 1'b1);
        for (int k = 0; k < 3000; k++) begin
            reset      = $urandom_range(0, 99) < 2;
            flush      = $urandom_range(0, 99) < 4;
            stall_down = $urandom_range(0, 99) < 15;
            in_exception_valid = $urandom_range(0, 9) == 0;
            in_exception = 4'($urandom);
            drive($urandom_range(0, 9) < 8, rand_instr(), $urandom);
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
